// File: rtl/stopwatch_pkg.sv
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared stopwatch encodings and digit widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } status_e;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;

endpackage

`default_nettype wire

// File: rtl/stopwatch_time_counter_if.sv
// ============================================================================
//  Module      : stopwatch_time_counter_if
//  Description : Control inputs and BCD display outputs of the time counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_time_counter_if;
    import stopwatch_pkg::*;

    logic             count_en;
    logic             clear;
    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] min_tens;
    logic             tick;
    logic             rollover;

    modport master (
        output count_en, clear,
        input  sec_ones, sec_tens, min_ones, min_tens, tick, rollover
    );

    modport slave (
        input  count_en, clear,
        output sec_ones, sec_tens, min_ones, min_tens, tick, rollover
    );

endinterface

`default_nettype wire

// File: rtl/stopwatch_time_counter_bcd_digit.sv
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD counter digit with run-time wrap point and carry out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             inc,
    input  wire logic [BCD_W-1:0] wrap_at,
    output logic      [BCD_W-1:0] q,
    output logic                  carry
);

    localparam logic [BCD_W-1:0] c_MAX = BCD_W'(MAX);

    logic [BCD_W-1:0] r_q;
    logic             w_legal;
    logic             w_wrap;

    // An out-of-range value (upset) returns to zero without rippling a carry.
    always_comb begin
        w_legal = (r_q <= c_MAX);
        w_wrap  = (r_q >= wrap_at) || !w_legal;
        carry   = inc && w_legal && (r_q >= wrap_at);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= w_wrap ? '0 : r_q + BCD_W'(1);
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_time_counter.sv
// ============================================================================
//  Module      : stopwatch_time_counter
//  Description : Prescaled BCD MM:SS counter with tick and rollover strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_MIN  = 99
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    stopwatch_time_counter_if.slave bus
);

    localparam int                 c_DIV_W    = $clog2(TICK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [BCD_W-1:0]   c_NINE     = BCD_W'(9);
    localparam logic [BCD_W-1:0]   c_SEC_TMAX = BCD_W'(SEC_TENS_MAX);
    localparam logic [BCD_W-1:0]   c_MAX_TENS = BCD_W'(MAX_MIN / 10);
    localparam logic [BCD_W-1:0]   c_MAX_ONES = BCD_W'(MAX_MIN % 10);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_tick;
    logic               r_rollover;
    logic               w_inc;
    logic [3:0]         w_carry;
    logic [BCD_W-1:0]   w_sec_ones;
    logic [BCD_W-1:0]   w_sec_tens;
    logic [BCD_W-1:0]   w_min_ones;
    logic [BCD_W-1:0]   w_min_tens;
    logic [BCD_W-1:0]   w_min_ones_wrap;

    assign w_inc = bus.count_en && !bus.clear && (r_div_cnt == c_DIV_LAST);

    // Prescaler freezes (keeps the partial second) while count_en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (bus.clear) begin
            r_div_cnt <= '0;
        end else if (bus.count_en) begin
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_W'(1);
        end
    end

    // Minute ones stops short of 9 only when tens sits on the MAX_MIN tens digit.
    assign w_min_ones_wrap = (w_min_tens == c_MAX_TENS) ? c_MAX_ONES : c_NINE;

    bcd_digit #(.MAX(9)) u_sec_ones (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.clear),
        .inc     (w_inc),
        .wrap_at (c_NINE),
        .q       (w_sec_ones),
        .carry   (w_carry[0])
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.clear),
        .inc     (w_carry[0]),
        .wrap_at (c_SEC_TMAX),
        .q       (w_sec_tens),
        .carry   (w_carry[1])
    );

    bcd_digit #(.MAX(9)) u_min_ones (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.clear),
        .inc     (w_carry[1]),
        .wrap_at (w_min_ones_wrap),
        .q       (w_min_ones),
        .carry   (w_carry[2])
    );

    bcd_digit #(.MAX(9)) u_min_tens (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.clear),
        .inc     (w_carry[2]),
        .wrap_at (c_MAX_TENS),
        .q       (w_min_tens),
        .carry   (w_carry[3])
    );

    // A carry out of the top digit is exactly the MAX_MIN:59 -> 00:00 event.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_tick     <= w_inc;
            r_rollover <= w_carry[3];
        end
    end

    assign bus.sec_ones = w_sec_ones;
    assign bus.sec_tens = w_sec_tens;
    assign bus.min_ones = w_min_ones;
    assign bus.min_tens = w_min_tens;
    assign bus.tick     = r_tick;
    assign bus.rollover = r_rollover;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
// ============================================================================
//  Module      : tb_stopwatch_time_counter
//  Description : Directed checks of the stopwatch time counter, TICK_DIV=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_time_counter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    stopwatch_time_counter_if sw_if ();

    stopwatch_time_counter #(
        .TICK_DIV (4),
        .MAX_MIN  (99)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        clear;
        logic        count_en;
        int          reps;
        logic [15:0] exp_time;
        logic        exp_tick;
        logic        exp_roll;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(string name, logic rn, logic clr, logic en, int reps,
                                logic [15:0] t, logic tk, logic rl);
        vec_t v;
        v.name = name; v.rst_n = rn; v.clear = clr; v.count_en = en; v.reps = reps;
        v.exp_time = t; v.exp_tick = tk; v.exp_roll = rl;
        return v;
    endfunction

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic cycle(input logic rn, input logic clr, input logic en);
        rst_n          = rn;
        sw_if.clear    = clr;
        sw_if.count_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] t, input logic tk, input logic rl);
        logic [15:0] act;
        act = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};
        n_checks++;
        if (act !== t) begin
            n_fails++;
            $display("FAIL %s time: got %h want %h", name, act, t);
        end
        n_checks++;
        if (sw_if.tick !== tk) begin
            n_fails++;
            $display("FAIL %s tick: got %b want %b", name, sw_if.tick, tk);
        end
        n_checks++;
        if (sw_if.rollover !== rl) begin
            n_fails++;
            $display("FAIL %s rollover: got %b want %b", name, sw_if.rollover, rl);
        end
    endtask

    task automatic run_enabled(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1);
    endtask

    task automatic step_check(input string name, input logic rn, input logic clr, input logic en,
                              input logic [15:0] t, input logic tk, input logic rl);
        cycle(rn, clr, en);
        check(name, t, tk, rl);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n          = 1'b0;
        sw_if.clear    = 1'b0;
        sw_if.count_en = 1'b0;

        // Reset, first increment, pause/resume holding the partial second.
        vecs[0]  = mk("reset",        1'b0, 1'b0, 1'b1, 2,  16'h0000, 1'b0, 1'b0);
        vecs[1]  = mk("pre_tick",     1'b1, 1'b0, 1'b1, 3,  16'h0000, 1'b0, 1'b0);
        vecs[2]  = mk("first_tick",   1'b1, 1'b0, 1'b1, 1,  16'h0001, 1'b1, 1'b0);
        vecs[3]  = mk("tick_end",     1'b1, 1'b0, 1'b0, 1,  16'h0001, 1'b0, 1'b0);
        vecs[4]  = mk("run_2",        1'b1, 1'b0, 1'b1, 2,  16'h0001, 1'b0, 1'b0);
        vecs[5]  = mk("paused",       1'b1, 1'b0, 1'b0, 10, 16'h0001, 1'b0, 1'b0);
        vecs[6]  = mk("resume_1",     1'b1, 1'b0, 1'b1, 1,  16'h0001, 1'b0, 1'b0);
        vecs[7]  = mk("resume_tick",  1'b1, 1'b0, 1'b1, 1,  16'h0002, 1'b1, 1'b0);
        vecs[8]  = mk("run_3",        1'b1, 1'b0, 1'b1, 3,  16'h0002, 1'b0, 1'b0);
        vecs[9]  = mk("last_en_tick", 1'b1, 1'b0, 1'b1, 1,  16'h0003, 1'b1, 1'b0);
        vecs[10] = mk("en_dropped",   1'b1, 1'b0, 1'b0, 1,  16'h0003, 1'b0, 1'b0);

        for (int v = 0; v < 11; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                cycle(vecs[v].rst_n, vecs[v].clear, vecs[v].count_en);
                check(vecs[v].name, vecs[v].exp_time, vecs[v].exp_tick, vecs[v].exp_roll);
            end
        end

        // 00:59 -> 01:00 carries through sec_tens into min_ones on one edge.
        step_check("clear_a", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_enabled(239);
        check("at_0059", 16'h0059, 1'b0, 1'b0);
        step_check("to_0100", 1'b1, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);

        // 99:59 -> 00:00 with rollover and tick together, then counting continues.
        step_check("clear_b", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_enabled(5999 * 4);
        check("at_9959", 16'h9959, 1'b1, 1'b0);
        run_enabled(3);
        check("hold_9959", 16'h9959, 1'b0, 1'b0);
        step_check("rollover", 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        step_check("roll_end", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_enabled(4);
        check("after_roll", 16'h0001, 1'b1, 1'b0);

        // clear wins over count_en on what would be an increment edge.
        step_check("clear_c", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_enabled(754 * 4 + 3);
        check("at_1234", 16'h1234, 1'b0, 1'b0);
        step_check("clear_vs_en", 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_enabled(3);
        check("post_clear_3", 16'h0000, 1'b0, 1'b0);
        step_check("post_clear_4", 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);

        // Reset mid-run on an increment edge, then a full prescale after release.
        step_check("clear_d", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_enabled(465 * 4 + 3);
        check("at_0745", 16'h0745, 1'b0, 1'b0);
        step_check("rst_mid_run", 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_enabled(3);
        check("post_rst_3", 16'h0000, 1'b0, 1'b0);
        step_check("post_rst_4", 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
